// File: rtl/camera_pkg.sv
// Shared constants and types for the CSI-2 style camera receiver.
// Imported by the lane deserializer and the packet-level top.
package camera_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hB8;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    CRC     = 3'd3,
    DONE    = 3'd4
  } state_e;

  function automatic logic is_long_dt(input logic [5:0] dt);
    return (dt >= DT_LONG_MIN);
  endfunction

endpackage

// File: rtl/camera_lane_deserializer.sv
// One data lane: DDR capture into an LSB-first shift register, sync-byte
// detection on either sample phase, and a byte strobe every 8 samples.
module camera_lane_deserializer
  import camera_pkg::*;
(
  input  logic       clock_p,
  input  logic       reset_n,
  input  logic       data_i,
  input  logic       sync_i,
  input  logic       sync_mid_i,
  output logic       match_mid_o,
  output logic       match_full_o,
  output logic [7:0] byte_o,
  output logic       strobe_o
);

  logic       neg_bit_d, neg_bit_q;
  logic [7:0] shift_d, shift_q;
  logic [7:0] sr_mid_s;
  logic [1:0] cnt_d, cnt_q;
  logic       phase_d, phase_q;
  logic [7:0] byte_d, byte_q;
  logic       strobe_d, strobe_q;

  // sr_mid_s is the register as it stood after the falling-edge sample;
  // a sync seen there puts every later byte boundary on that phase too.
  always_comb begin
    neg_bit_d    = data_i;
    sr_mid_s     = {neg_bit_q, shift_q[7:1]};
    shift_d      = {data_i, neg_bit_q, shift_q[7:2]};
    match_mid_o  = (sr_mid_s == SYNC_BYTE);
    match_full_o = (shift_d == SYNC_BYTE);
    phase_d      = phase_q;
    cnt_d        = cnt_q + 2'd1;
    byte_d       = byte_q;
    strobe_d     = 1'b0;
    if (sync_i) begin
      phase_d = sync_mid_i;
      cnt_d   = 2'd0;
    end else if (cnt_q == 2'd3) begin
      strobe_d = 1'b1;
      byte_d   = phase_q ? sr_mid_s : shift_d;
    end else begin
      strobe_d = 1'b0;
    end
  end

  // Falling-edge half of the DDR capture.
  always_ff @(negedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      neg_bit_q <= 1'b0;
    end else begin
      neg_bit_q <= neg_bit_d;
    end
  end

  // Rising-edge shift, byte counter and registered byte strobe.
  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= 8'h00;
      cnt_q    <= 2'd0;
      phase_q  <= 1'b0;
      byte_q   <= 8'h00;
      strobe_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
    end
  end

  assign byte_o   = byte_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/camera.sv
// CSI-2 style receiver top: lane sync, packet FSM, header capture and
// 32-bit payload word assembly with interrupt per word and per packet end.
module camera
  import camera_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                 clock_p,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] data_p,
  output logic [1:0]           virtual_channel,
  output logic [15:0]          word_count,
  output logic [7:0]           image_data [3:0],
  output logic [5:0]           image_data_type,
  output logic                 image_data_enable,
  output logic                 interrupt
);

  logic [NUM_LANES-1:0] match_mid_s, match_full_s, strobe_s;
  logic [7:0]           lane_byte_s [NUM_LANES];
  logic                 sync_s, sync_mid_s, load_s, take_s, last_s;
  logic [7:0]           cur_s;
  logic [16:0]          wc_ext_s;
  logic [7:0]           header_ecc;

  state_e          state_d, state_q;
  logic [3:0][7:0] buf_d, buf_q;
  logic [2:0]      rem_d, rem_q;
  logic [1:0]      sel_d, sel_q;
  logic [16:0]     cnt_d, cnt_q;
  logic [7:0]      did_d, did_q;
  logic [15:0]     wc_tmp_d, wc_tmp_q;
  logic [3:0][7:0] word_d, word_q;
  logic [1:0]      wpos_d, wpos_q;
  logic [1:0]      vc_d, vc_q;
  logic [15:0]     wc_d, wc_q;
  logic [5:0]      dt_d, dt_q;
  logic [7:0]      ecc_d, ecc_q;
  logic [3:0][7:0] img_d, img_q;
  logic            en_d, en_q;
  logic            irq_d, irq_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    camera_lane_deserializer u_lane (
      .clock_p      (clock_p),
      .reset_n      (reset_n),
      .data_i       (data_p[l]),
      .sync_i       (sync_s),
      .sync_mid_i   (sync_mid_s),
      .match_mid_o  (match_mid_s[l]),
      .match_full_o (match_full_s[l]),
      .byte_o       (lane_byte_s[l]),
      .strobe_o     (strobe_s[l])
    );
  end

  // All lanes strobe together; their bytes are buffered and walked one per
  // cycle, which always finishes before the next strobe 4 cycles later.
  always_comb begin
    sync_s     = (state_q == HUNT) && ((&match_full_s) || (&match_mid_s));
    sync_mid_s = ~(&match_full_s);
    load_s     = (|strobe_s) &&
                 ((state_q == HEADER) || (state_q == PAYLOAD) || (state_q == CRC));
    take_s     = (rem_q != 3'd0);
    cur_s      = buf_q[sel_q];
    wc_ext_s   = {1'b0, wc_q};
    last_s     = (cnt_q == wc_ext_s + 17'd3);

    state_d  = state_q;
    buf_d    = buf_q;
    rem_d    = rem_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    did_d    = did_q;
    wc_tmp_d = wc_tmp_q;
    word_d   = word_q;
    wpos_d   = wpos_q;
    vc_d     = vc_q;
    wc_d     = wc_q;
    dt_d     = dt_q;
    ecc_d    = ecc_q;
    img_d    = img_q;
    en_d     = 1'b0;
    irq_d    = 1'b0;

    if (take_s) begin
      rem_d = rem_q - 3'd1;
      sel_d = sel_q + 2'd1;
    end else begin
      rem_d = rem_q;
    end

    case (state_q)
      HUNT: begin
        if (sync_s) begin
          state_d = HEADER;
          cnt_d   = 17'd0;
          rem_d   = 3'd0;
          sel_d   = 2'd0;
          word_d  = '0;
          wpos_d  = 2'd0;
        end else begin
          rem_d = 3'd0;
        end
      end
      HEADER: begin
        if (take_s) begin
          cnt_d = cnt_q + 17'd1;
          case (cnt_q[1:0])
            2'd0: did_d = cur_s;
            2'd1: wc_tmp_d[7:0] = cur_s;
            2'd2: wc_tmp_d[15:8] = cur_s;
            default: begin
              ecc_d = cur_s;
              vc_d  = did_q[7:6];
              dt_d  = did_q[5:0];
              wc_d  = wc_tmp_q;
              if (!is_long_dt(did_q[5:0])) begin
                irq_d   = 1'b1;
                state_d = DONE;
              end else if (wc_tmp_q == 16'h0000) begin
                state_d = CRC;
              end else begin
                state_d = PAYLOAD;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      PAYLOAD: begin
        if (take_s) begin
          cnt_d          = cnt_q + 17'd1;
          word_d[wpos_q] = cur_s;
          wpos_d         = wpos_q + 2'd1;
          if ((wpos_q == 2'd3) || last_s) begin
            img_d         = word_q;
            img_d[wpos_q] = cur_s;
            en_d          = 1'b1;
            irq_d         = 1'b1;
            word_d        = '0;
            wpos_d        = 2'd0;
            state_d       = last_s ? CRC : PAYLOAD;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      CRC: begin
        if (take_s) begin
          cnt_d = cnt_q + 17'd1;
          if (cnt_q == wc_ext_s + 17'd5) begin
            irq_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CRC;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        state_d = HUNT;
        rem_d   = 3'd0;
      end
      default: begin
        state_d = HUNT;
        rem_d   = 3'd0;
      end
    endcase

    if (load_s) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        buf_d[i] = lane_byte_s[i];
      end
      rem_d = 3'(NUM_LANES);
      sel_d = 2'd0;
    end else begin
      buf_d = buf_d;
    end
  end

  // Packet state, header registers and registered outputs.
  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HUNT;
      buf_q    <= '0;
      rem_q    <= 3'd0;
      sel_q    <= 2'd0;
      cnt_q    <= 17'd0;
      did_q    <= 8'h00;
      wc_tmp_q <= 16'h0000;
      word_q   <= '0;
      wpos_q   <= 2'd0;
      vc_q     <= 2'd0;
      wc_q     <= 16'h0000;
      dt_q     <= 6'h00;
      ecc_q    <= 8'h00;
      img_q    <= '0;
      en_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      rem_q    <= rem_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      did_q    <= did_d;
      wc_tmp_q <= wc_tmp_d;
      word_q   <= word_d;
      wpos_q   <= wpos_d;
      vc_q     <= vc_d;
      wc_q     <= wc_d;
      dt_q     <= dt_d;
      ecc_q    <= ecc_d;
      img_q    <= img_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_img
    assign image_data[i] = img_q[i];
  end

  assign header_ecc        = ecc_q;
  assign virtual_channel   = vc_q;
  assign word_count        = wc_q;
  assign image_data_type   = dt_q;
  assign image_data_enable = en_q;
  assign interrupt         = irq_q;

endmodule

// File: tb/tb_camera.sv
// Table-driven bench: the same packets are serialised onto 1-, 2- and
// 4-lane instances and each instance's interrupt events are compared.
module tb_camera;

  typedef struct packed {
    logic [7:0]        nbytes;
    logic [7:0]        lead;
    logic [23:0][7:0]  pkt;
    logic [2:0]        nexp;
    logic [3:0]        exp_en;
    logic [3:0][31:0]  exp_data;
    logic [1:0]        vc;
    logic [5:0]        dt;
    logic [15:0]       wc;
    logic [7:0]        ecc;
  } tvec_t;

  typedef struct packed {
    logic [1:0]  dut;
    logic        en;
    logic [31:0] data;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc;
  } ev_t;

  logic        clock_p = 1'b0;
  logic        reset_n = 1'b0;
  logic [0:0]  dp1 = '0;
  logic [1:0]  dp2 = '0;
  logic [3:0]  dp4 = '0;
  logic [1:0]  vc1, vc2, vc4;
  logic [15:0] wc1, wc2, wc4;
  logic [5:0]  dt1, dt2, dt4;
  logic [7:0]  img1 [3:0];
  logic [7:0]  img2 [3:0];
  logic [7:0]  img4 [3:0];
  logic        en1, en2, en4, irq1, irq2, irq4;

  int    n_checks = 0;
  int    n_errors = 0;
  int    viol = 0;
  ev_t   evq[$];
  tvec_t tv [6];

  always #5 clock_p = ~clock_p;

  camera #(.NUM_LANES(1)) dut1 (
    .clock_p(clock_p), .reset_n(reset_n), .data_p(dp1), .virtual_channel(vc1),
    .word_count(wc1), .image_data(img1), .image_data_type(dt1),
    .image_data_enable(en1), .interrupt(irq1));
  camera #(.NUM_LANES(2)) dut2 (
    .clock_p(clock_p), .reset_n(reset_n), .data_p(dp2), .virtual_channel(vc2),
    .word_count(wc2), .image_data(img2), .image_data_type(dt2),
    .image_data_enable(en2), .interrupt(irq2));
  camera #(.NUM_LANES(4)) dut4 (
    .clock_p(clock_p), .reset_n(reset_n), .data_p(dp4), .virtual_channel(vc4),
    .word_count(wc4), .image_data(img4), .image_data_type(dt4),
    .image_data_enable(en4), .interrupt(irq4));

  // Record every interrupt cycle, sampled half a cycle after the update.
  always @(negedge clock_p) begin
    if (irq1) evq.push_back(ev_t'{dut: 2'd0, en: en1, data: {img1[3], img1[2], img1[1], img1[0]},
                                  vc: vc1, dt: dt1, wc: wc1, ecc: dut1.header_ecc});
    if (irq2) evq.push_back(ev_t'{dut: 2'd1, en: en2, data: {img2[3], img2[2], img2[1], img2[0]},
                                  vc: vc2, dt: dt2, wc: wc2, ecc: dut2.header_ecc});
    if (irq4) evq.push_back(ev_t'{dut: 2'd2, en: en4, data: {img4[3], img4[2], img4[1], img4[0]},
                                  vc: vc4, dt: dt4, wc: wc4, ecc: dut4.header_ecc});
    if ((en1 && !irq1) || (en2 && !irq2) || (en4 && !irq4)) viol++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  function automatic logic [23:0][7:0] pk(input logic [191:0] s, input int n);
    logic [23:0][7:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = s[(n-1-i)*8 +: 8];
    return r;
  endfunction

  function automatic tvec_t mk_tv(input int n, input int lead, input logic [191:0] s,
                                  input int nexp, input logic [3:0] en, input logic [127:0] data,
                                  input logic [1:0] vc, input logic [5:0] dt,
                                  input logic [15:0] wc, input logic [7:0] ecc);
    tvec_t v;
    v.nbytes = 8'(n);   v.lead = 8'(lead);  v.pkt = pk(s, n);
    v.nexp = 3'(nexp);  v.exp_en = en;      v.exp_data = data;
    v.vc = vc; v.dt = dt; v.wc = wc; v.ecc = ecc;
    return v;
  endfunction

  // Lane `lane` of an nl-lane link at sample s: idle, sync byte, then bytes
  // dealt round-robin across lanes, 0xFF where the packet has run out.
  function automatic logic lane_bit(input tvec_t v, input int nl, input int lane, input int s);
    int t, slot, idx, nslots;
    logic [7:0] b;
    if (s < int'(v.lead)) return 1'b0;
    t = s - int'(v.lead);
    slot = t / 8;
    nslots = (int'(v.nbytes) + nl - 1) / nl;
    if (slot == 0) begin
      b = 8'hB8;
    end else if (slot - 1 < nslots) begin
      idx = (slot - 1) * nl + lane;
      b = (idx < int'(v.nbytes)) ? v.pkt[idx] : 8'hFF;
    end else begin
      b = 8'h00;
    end
    return b[t % 8];
  endfunction

  task automatic send(input tvec_t v, input int nsamp);
    for (int s = 0; s < nsamp; s++) begin
      @(posedge clock_p or negedge clock_p);
      #1;
      dp1[0] = lane_bit(v, 1, 0, s);
      for (int l = 0; l < 2; l++) dp2[l] = lane_bit(v, 2, l, s);
      for (int l = 0; l < 4; l++) dp4[l] = lane_bit(v, 4, l, s);
    end
  endtask

  task automatic send_idle(input int nsamp);
    for (int s = 0; s < nsamp; s++) begin
      @(posedge clock_p or negedge clock_p);
      #1;
      dp1 = '0; dp2 = '0; dp4 = '0;
    end
  endtask

  task automatic check_dut(input tvec_t v, input int t, input int d);
    ev_t got[$];
    string tag;
    tag = $sformatf("t%0d_lanes%0d", t, (d == 0) ? 1 : (d == 1) ? 2 : 4);
    foreach (evq[i]) if (int'(evq[i].dut) == d) got.push_back(evq[i]);
    check({tag, "_irq_count"}, 64'(got.size()), 64'(v.nexp));
    for (int i = 0; i < int'(v.nexp) && i < got.size(); i++) begin
      check($sformatf("%s_ev%0d_enable", tag, i), 64'(got[i].en), 64'(v.exp_en[i]));
      if (v.exp_en[i]) check($sformatf("%s_ev%0d_data", tag, i), 64'(got[i].data), 64'(v.exp_data[i]));
      check($sformatf("%s_ev%0d_hdr{vc,dt,wc,ecc}", tag, i),
            64'({got[i].vc, got[i].dt, got[i].wc, got[i].ecc}),
            64'({v.vc, v.dt, v.wc, v.ecc}));
    end
  endtask

  task automatic run_test(input int t);
    send(tv[t], int'(tv[t].lead) + 8 * (1 + int'(tv[t].nbytes)) + 64);
    for (int d = 0; d < 3; d++) check_dut(tv[t], t, d);
    evq.delete();
  endtask

  function automatic logic [63:0] outs(input int d);
    case (d)
      0: return 64'({irq1, en1, img1[3], img1[2], img1[1], img1[0], vc1, dt1, wc1, dut1.header_ecc});
      1: return 64'({irq2, en2, img2[3], img2[2], img2[1], img2[0], vc2, dt2, wc2, dut2.header_ecc});
      default: return 64'({irq4, en4, img4[3], img4[2], img4[1], img4[0], vc4, dt4, wc4, dut4.header_ecc});
    endcase
  endfunction

  initial begin
    tv[0] = mk_tv(4, 5, 192'h08CEFA12, 1, 4'b0000, 128'h0, 2'd0, 6'h08, 16'hFACE, 8'h12);
    tv[1] = mk_tv(14, 8, 192'h180800FEADDEE1FE5EEA150DD0F0, 3, 4'b0011,
                  128'h00000000_00000000_0D15EA5E_FEE1DEAD, 2'd0, 6'h18, 16'h0008, 8'hFE);
    tv[2] = mk_tv(11, 3, 192'h6A05003C1122334455AABB, 3, 4'b0011,
                  128'h00000000_00000000_00000055_44332211, 2'd1, 6'h2A, 16'h0005, 8'h3C);
    tv[3] = mk_tv(6, 12, 192'hD20000770102, 1, 4'b0000, 128'h0, 2'd3, 6'h12, 16'h0000, 8'h77);
    tv[4] = mk_tv(4, 7, 192'h4F34125A, 1, 4'b0000, 128'h0, 2'd1, 6'h0F, 16'h1234, 8'h5A);
    tv[5] = mk_tv(7, 9, 192'h100100E39CC1C2, 2, 4'b0001,
                  128'h00000000_00000000_00000000_0000009C, 2'd0, 6'h10, 16'h0001, 8'hE3);

    repeat (3) @(posedge clock_p);
    #2;
    for (int d = 0; d < 3; d++) check($sformatf("reset_outputs_d%0d", d), outs(d), 64'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock_p);

    for (int t = 0; t < 6; t++) run_test(t);

    // Reset partway into a long packet: outputs clear at once, no event.
    send(tv[1], int'(tv[1].lead) + 8 * 2 + 4);
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("midpkt_reset_outputs_d%0d", d), outs(d), 64'h0);
    send_idle(8);
    reset_n = 1'b1;
    send_idle(56);
    check("midpkt_reset_no_irq", 64'(evq.size()), 64'h0);
    evq.delete();
    run_test(1);

    check("enable_without_irq", 64'(viol), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/camera.md
CAMERA -- requirements
Module: camera

Interface
REQ-001 The module SHALL have parameter NUM_LANES, default 2, meaning the number of CSI-2 data lanes; legal values are 1, 2 and 4.
REQ-002 The module SHALL have port clock_p, input, 1 bit: the D-PHY clock lane (positive leg) and the only clock; data is DDR on both of its edges.
REQ-003 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port data_p, input, NUM_LANES bits: positive legs of the data lanes.
REQ-005 The module SHALL have port virtual_channel, output, 2 bits: VC of the current packet (Data ID bits 7:6).
REQ-006 The module SHALL have port word_count, output, 16 bits: packet header WC field, {byte2, byte1}.
REQ-007 The module SHALL have port image_data, output, 4x8 bits (unpacked [3:0]): payload word, where element 0 is the earliest byte.
REQ-008 The module SHALL have port image_data_type, output, 6 bits: Data Type (Data ID bits 5:0).
REQ-009 The module SHALL have port image_data_enable, output, 1 bit: image_data is valid this cycle.
REQ-010 The module SHALL have port interrupt, output, 1 bit: a packet event occurred; header outputs are valid.
REQ-011 The module SHALL expose an internal signal header_ecc (8 bits) that holds the captured header ECC byte, so that hierarchical checks can read it.

Function
REQ-012 Each lane SHALL sample data_p on both rising and falling edges of clock_p, LSB first, shifting each bit into the MSB of an 8-bit per-lane shift register.
REQ-013 In HUNT state, sync SHALL be declared when every lane's shift register equals 0xB8 (8'b10111000) on the same sample; this fixes the byte boundaries.
REQ-014 After sync, byte n of the packet SHALL be taken from lane (n mod NUM_LANES), in lane order, one byte per lane every 8 samples (4 clock_p cycles).
REQ-015 Header byte order SHALL be: Data ID, WC LSB, WC MSB, ECC; header_ecc, virtual_channel, word_count and image_data_type SHALL be registered when the 4th byte arrives and SHALL hold until the next header.
REQ-016 ECC SHALL be captured but not checked or corrected; CRC SHALL be consumed but not checked.
REQ-017 Data types 0x00-0x0F SHALL be short packets: interrupt SHALL be high for exactly one clock_p cycle after the header completes, with image_data_enable low, and the module SHALL then return to HUNT.
REQ-018 Data types 0x10-0x3F SHALL be long packets: word_count payload bytes follow, then 2 CRC bytes.
REQ-019 In a long packet, each 4 payload bytes SHALL be assembled into image_data and presented with image_data_enable=1 and interrupt=1 for one clock_p cycle.
REQ-020 In a long packet, interrupt SHALL NOT assert at header completion.
REQ-021 If word_count mod 4 is not 0, the final word SHALL be emitted after the last payload byte, zero-padded in the upper elements.
REQ-022 After both CRC bytes, interrupt SHALL be high for exactly one cycle with image_data_enable=0 (end of packet), and the module SHALL then return to HUNT.
REQ-023 word_count=0 on a long packet SHALL produce no enable pulses, only the end-of-packet interrupt after the CRC.
REQ-024 All outputs SHALL be registered and update on rising clock_p.
REQ-025 image_data_enable SHALL never be high without interrupt.
REQ-026 Bytes spanning more lanes than remain in a packet (packet length not a multiple of NUM_LANES) SHALL be ignored as lane padding.
REQ-027 The byte counter SHALL be 16-bit plus the header/CRC offset, with no wrap within a packet (maximum WC 0xFFFF).

Reset
REQ-028 When reset_n is low, the module SHALL asynchronously enter HUNT, clear the shift registers and counters, and drive all outputs to 0 (including header_ecc).
REQ-029 Reset mid-packet SHALL discard the partial packet; no interrupt SHALL fire for it.

Structure
REQ-030 A shared package camera_pkg SHALL hold SYNC_BYTE=8'hB8, the short/long data-type boundary 6'h10, and the FSM state enum (HUNT, HEADER, PAYLOAD, CRC, DONE).
REQ-031 The sub-module camera_lane_deserializer (DDR capture, shift register, sync match, byte strobe) SHALL be instantiated NUM_LANES times; the top holds the FSM, header registers and word assembler.

Verification
REQ-032 Short packet, 2 lanes: lanes send B8/B8, then 08, CE, FA, 12 -> one interrupt with vc=0, image_data_type=08, word_count=FACE, header_ecc=12, enable=0.
REQ-033 Long packet, 2 lanes: B8/B8, 18, 08, 00, FE, payload AD DE E1 FE 5E EA 15 0D, CRC D0 F0 -> enable pulses image_data=FEE1DEAD then 0D15EA5E, then interrupt with enable=0; word_count=0008, image_data_type=18.
REQ-034 Back-to-back: the short packet then the long packet -> both are decoded and return to HUNT between them.
REQ-035 Partial word: long packet with WC=5 -> second word = 000000xx plus end-of-packet interrupt.
REQ-036 Reset_n pulsed low mid-payload -> outputs are 0 immediately, no interrupt, and the next sync decodes correctly.
REQ-037 NUM_LANES=1 and 4 -> the REQ-033 packet yields identical outputs.
